jtag_1149_d10_crc_engine: RTL and testbench
===========================================

# jtag_1149_d10_crc_engine

Parametrised CRC engine for the IEEE 1149.10 packet path. It replaces the fixed 32-bit CRC-32 LFSR used on frame data. Width, polynomial, init, reflection and final XOR are configurable. It accepts byte-enabled beats over a valid/ready handshake and tracks frame boundaries with a small state machine. For each frame it returns a registered CRC result, an optional compare against an expected CRC, and protocol error flags.

## Interface
Parameters:
- DATA_W, 32: beat width in bits; multiple of 8, from 8 to 128.
- CRC_W, 32: CRC width in bits, from 8 to 32.
- POLY, 32'h04C11DB7: generator polynomial, implicit top bit omitted.
- INIT, 32'h0000_0000: LFSR value loaded at start of frame.
- XOR_OUT, 32'h0000_0000: XORed into the result after reflection.
- REFLECT_IN, 0: 1 = bit-reverse each input byte before processing.
- REFLECT_OUT, 0: 1 = bit-reverse the full CRC_W result.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  engine can accept a beat
- in_data  in  DATA_W  beat data; byte lane DATA_W/8-1 (MSB) is processed first
- in_be  in  DATA_W/8  byte enables; must be contiguous from MSB
- in_sop  in  1  first beat of frame
- in_eop  in  1  last beat of frame
- chk_en  in  1  compare enable, sampled on the eop beat
- chk_crc  in  CRC_W  expected CRC, sampled on the eop beat
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- crc_out  out  CRC_W  final CRC
- crc_match  out  1  crc_out == chk_crc (0 when chk_en was 0)
- byte_cnt  out  16  bytes in frame, saturating at 16'hFFFF
- proto_err  out  1  protocol error seen in this frame
- be_err  out  1  illegal byte enable seen in this frame

## Operation
- A beat is accepted when in_valid && in_ready.
- States:
  - IDLE: after reset or after a result is delivered.
  - ACTIVE: frame in progress.
  - DONE: result held on the outputs.
- IDLE → ACTIVE: accepted beat without eop.
- IDLE → DONE: accepted beat with eop (single-beat frame).
- ACTIVE → DONE: accepted beat with eop.
- DONE → IDLE: out_ready with no eop beat accepted in the same cycle.
- DONE → ACTIVE: out_ready while a non-eop beat is accepted.
- DONE → DONE: out_ready while an eop beat is accepted.
- LFSR update on each accepted beat:
  - Start from INIT if the beat has in_sop or the state is IDLE/DONE; otherwise start from the current LFSR.
  - Process enabled bytes in MSB-first order, one byte per chained step.
- Legal in_be: a nonzero pattern of ones from the MSB followed by zeros (e.g. 1111, 1110, 1100, 1000).
- Illegal in_be (zero or non-contiguous): the beat is processed as all-ones and the frame's be_err is set.
- Result = (REFLECT_OUT ? reverse(lfsr) : lfsr) ^ XOR_OUT[CRC_W-1:0].
- byte_cnt counts enabled bytes, using popcount of the effective enables.
- in_sop while ACTIVE: the old frame is discarded, a new frame starts from INIT, and proto_err is set for the new frame.
- Beat without in_sop in IDLE/DONE: it starts a frame and sets proto_err.
- in_sop and in_eop on the same beat is a legal single-beat frame.

## Timing
- Reset values: out_valid 0, crc_out 0, crc_match 0, byte_cnt 0, proto_err 0, be_err 0, state IDLE, LFSR = INIT. in_ready is 0 while rst is high.
- in_ready = !rst && (state != DONE || out_ready). This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: an eop beat accepted at edge N drives out_valid = 1 with all result fields valid after edge N.
- All result outputs are registered and held stable while out_valid && !out_ready.
- Throughput is one beat per cycle, including back-to-back frames when out_ready is held high.
- Reset asserted mid-frame: the engine aborts immediately, with no result and no flags.

## Structure
- Package jtag_1149_d10_crc_pkg holds:
  - the state enum (IDLE, ACTIVE, DONE);
  - default CRC-32 constants (POLY, INIT, XOR_OUT);
  - the reflect and byte-enable legality functions.
- Sub-module jtag_1149_d10_crc_byte: combinational single-byte LFSR step (CRC_W, POLY). It is instantiated DATA_W/8 times in a chain, with each lane bypassed when its enable is 0.

## Test plan
- Defaults, "123456789" as beats 0x31323334 (be 1111, sop), 0x35363738 (be 1111), 0x39xxxxxx (be 1000, eop) → crc_out 0x89A1897F, byte_cnt 9.
- INIT/XOR_OUT = 0xFFFFFFFF, REFLECT_IN = REFLECT_OUT = 1, same stream → crc_out 0xCBF43926. With chk_en = 1 and chk_crc = 0xCBF43926 → crc_match 1; with chk_crc = 0 → crc_match 0.
- out_ready held 0 for 5 cycles after a result → in_ready 0, outputs stable. Then out_ready 1 together with a new sop beat → beat accepted the same cycle.
- in_be 1010 on the middle beat → be_err 1, CRC equal to the all-ones-enable CRC.
- in_sop mid-frame → first frame gives no result, second frame's CRC is correct, proto_err 1.
- rst pulsed during ACTIVE → out_valid stays 0, and the next frame gives 0x89A1897F.

Source files
------------

// File: rtl/jtag_1149_d10_crc_pkg.sv
// Shared types, default CRC-32 constants and bit-manipulation helpers for the CRC engine.
package jtag_1149_d10_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } crc_state_e;

    localparam logic [31:0] DEF_POLY    = 32'h04C11DB7;
    localparam logic [31:0] DEF_INIT    = 32'h0000_0000;
    localparam logic [31:0] DEF_XOR_OUT = 32'h0000_0000;

    function automatic logic [7:0] reflect_byte(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] reflect_bits(input logic [31:0] v, input int w);
        logic [31:0] r;
        logic [4:0]  idx;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                idx  = 5'(w - 1 - i);
                r[i] = v[idx];
            end
        end
        return r;
    endfunction

    // Legal: top lane set and no enabled lane below a disabled one.
    function automatic logic be_is_legal(input logic [15:0] be, input int nb);
        logic ok;
        logic seen_zero;
        ok        = 1'b1;
        seen_zero = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (i < nb) begin
                if (!be[i]) begin
                    seen_zero = 1'b1;
                end else if (seen_zero) begin
                    ok = 1'b0;
                end
            end
        end
        return ok && be[4'(nb - 1)];
    endfunction

endpackage

// File: rtl/jtag_1149_d10_crc_byte.sv
// One byte of MSB-first LFSR update; purely combinational, chained once per byte lane.
module jtag_1149_d10_crc_byte
    import jtag_1149_d10_crc_pkg::*;
#(
    parameter int          CRC_W = 32,
    parameter logic [31:0] POLY  = DEF_POLY
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[CRC_W-1] ^ data[i]) begin
                c = (c << 1) ^ POLY[CRC_W-1:0];
            end else begin
                c = c << 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/jtag_1149_d10_crc_engine.sv
// Framed, byte-enabled CRC engine: one beat per cycle, result registered on the eop edge.
// Results are held until out_ready; in_ready drops only while an unconsumed result is pending.
module jtag_1149_d10_crc_engine
    import jtag_1149_d10_crc_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          CRC_W       = 32,
    parameter logic [31:0] POLY        = DEF_POLY,
    parameter logic [31:0] INIT        = DEF_INIT,
    parameter logic [31:0] XOR_OUT     = DEF_XOR_OUT,
    parameter bit          REFLECT_IN  = 1'b0,
    parameter bit          REFLECT_OUT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_be,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic                chk_en,
    input  logic [CRC_W-1:0]    chk_crc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CRC_W-1:0]    crc_out,
    output logic                crc_match,
    output logic [15:0]         byte_cnt,
    output logic                proto_err,
    output logic                be_err
);

    localparam int NB = DATA_W / 8;

    crc_state_e               state, state_nxt;
    logic [CRC_W-1:0]         lfsr, seed, crc_final;
    logic [NB:0][CRC_W-1:0]   chain;
    logic                     accept, start_new, be_ok, proto_hit;
    logic [NB-1:0]            eff_be;
    logic [4:0]               lane_cnt;
    logic [16:0]              cnt_sum;
    logic [15:0]              cnt_acc, cnt_base, cnt_nxt;
    logic                     perr_acc, beerr_acc, perr_nxt, beerr_nxt;
    logic [31:0]              lfsr_wide, lfsr_refl;

    assign in_ready  = !rst && (state != ST_DONE || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    assign be_ok     = be_is_legal(16'(in_be), NB);
    assign eff_be    = be_ok ? in_be : '1;
    // Any beat outside an active frame opens a new one, sop or not.
    assign start_new = in_sop || (state != ST_ACTIVE);
    assign proto_hit = (state == ST_ACTIVE) ? in_sop : !in_sop;
    assign seed      = start_new ? INIT[CRC_W-1:0] : lfsr;
    assign chain[0]  = seed;

    for (genvar j = 0; j < NB; j++) begin : g_lane
        localparam int LANE = NB - 1 - j;
        logic [7:0]       raw, lane_byte;
        logic [CRC_W-1:0] stepped;

        assign raw       = in_data[LANE*8 +: 8];
        assign lane_byte = REFLECT_IN ? reflect_byte(raw) : raw;

        jtag_1149_d10_crc_byte #(
            .CRC_W (CRC_W),
            .POLY  (POLY)
        ) u_step (
            .crc_in  (chain[j]),
            .data    (lane_byte),
            .crc_out (stepped)
        );

        assign chain[j+1] = eff_be[LANE] ? stepped : chain[j];
    end

    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            lane_cnt = lane_cnt + 5'(eff_be[i]);
        end
        cnt_base  = start_new ? 16'h0 : cnt_acc;
        cnt_sum   = {1'b0, cnt_base} + 17'(lane_cnt);
        cnt_nxt   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        perr_nxt  = (!start_new && perr_acc) || proto_hit;
        beerr_nxt = (!start_new && beerr_acc) || !be_ok;
        lfsr_wide = 32'(chain[NB]);
        lfsr_refl = reflect_bits(lfsr_wide, CRC_W);
        crc_final = (REFLECT_OUT ? lfsr_refl[CRC_W-1:0] : chain[NB]) ^ XOR_OUT[CRC_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACTIVE: begin
                if (accept) state_nxt = in_eop ? ST_DONE : ST_ACTIVE;
            end
            ST_DONE: begin
                if (out_ready) state_nxt = accept ? (in_eop ? ST_DONE : ST_ACTIVE) : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= INIT[CRC_W-1:0];
            cnt_acc   <= '0;
            perr_acc  <= 1'b0;
            beerr_acc <= 1'b0;
        end else if (accept) begin
            lfsr      <= chain[NB];
            cnt_acc   <= cnt_nxt;
            perr_acc  <= perr_nxt;
            beerr_acc <= beerr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_out   <= '0;
            crc_match <= 1'b0;
            byte_cnt  <= '0;
            proto_err <= 1'b0;
            be_err    <= 1'b0;
        end else if (accept && in_eop) begin
            crc_out   <= crc_final;
            crc_match <= chk_en && (crc_final == chk_crc);
            byte_cnt  <= cnt_nxt;
            proto_err <= perr_nxt;
            be_err    <= beerr_nxt;
        end
    end

endmodule

// File: tb/tb_jtag_1149_d10_crc_engine.sv
// Two engines (plain CRC-32/init 0 and standard reflected CRC-32) share one stimulus stream;
// a scoreboard queue of expected results is drained by an independent monitor.
module tb_jtag_1149_d10_crc_engine;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] crc_a;
        logic [31:0] crc_b;
        logic        m_a;
        logic        m_b;
        logic [15:0] cnt;
        logic        perr;
        logic        beerr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sop, in_eop, chk_en, out_ready;
    logic [31:0] in_data, chk_crc;
    logic [3:0]  in_be;
    logic        in_ready_a, out_valid_a, crc_match_a, proto_err_a, be_err_a;
    logic        in_ready_b, out_valid_b, crc_match_b, proto_err_b, be_err_b;
    logic [31:0] crc_out_a, crc_out_b;
    logic [15:0] byte_cnt_a, byte_cnt_b;

    int   tests = 0;
    int   fails = 0;
    int   rdy_mode = 2;
    exp_t exp_q[$];
    bq_t  frame_bytes;
    bit   in_frame = 1'b0;
    logic m_perr, m_beerr;
    bit   dir_en = 1'b0;
    logic [31:0] dir_a, dir_b;

    always #5 clk = ~clk;

    jtag_1149_d10_crc_engine u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_be(in_be), .in_sop(in_sop), .in_eop(in_eop),
        .chk_en(chk_en), .chk_crc(chk_crc), .out_valid(out_valid_a), .out_ready(out_ready),
        .crc_out(crc_out_a), .crc_match(crc_match_a), .byte_cnt(byte_cnt_a),
        .proto_err(proto_err_a), .be_err(be_err_a)
    );

    jtag_1149_d10_crc_engine #(
        .INIT(32'hFFFF_FFFF), .XOR_OUT(32'hFFFF_FFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_be(in_be), .in_sop(in_sop), .in_eop(in_eop),
        .chk_en(chk_en), .chk_crc(chk_crc), .out_valid(out_valid_b), .out_ready(out_ready),
        .crc_out(crc_out_b), .crc_match(crc_match_b), .byte_cnt(byte_cnt_b),
        .proto_err(proto_err_b), .be_err(be_err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic bit be_legal_m(input logic [3:0] be);
        return (be == 4'b1000) || (be == 4'b1100) || (be == 4'b1110) || (be == 4'b1111);
    endfunction

    function automatic bq_t append_beat(input bq_t base, input logic [31:0] d, input logic [3:0] be);
        bq_t q;
        logic [3:0] e;
        q = base;
        e = be_legal_m(be) ? be : 4'hF;
        for (int k = 3; k >= 0; k--) begin
            if (e[k]) q.push_back(d[k*8 +: 8]);
        end
        return q;
    endfunction

    function automatic logic [31:0] crc_a_of(input bq_t q);
        logic [31:0] c;
        c = 32'h0;
        foreach (q[i]) begin
            c = c ^ {q[i], 24'h0};
            repeat (8) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_b_of(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic model_beat(input logic [31:0] d, input logic [3:0] be, input logic sop,
                              input logic eop, input logic ce, input logic [31:0] cc);
        exp_t e;
        if (sop || !in_frame) begin
            frame_bytes.delete();
            m_perr  = 1'b0;
            m_beerr = 1'b0;
        end
        if (sop == in_frame) m_perr = 1'b1;
        if (!be_legal_m(be)) m_beerr = 1'b1;
        frame_bytes = append_beat(frame_bytes, d, be);
        if (eop) begin
            e.crc_a = dir_en ? dir_a : crc_a_of(frame_bytes);
            e.crc_b = dir_en ? dir_b : crc_b_of(frame_bytes);
            e.m_a   = ce && (e.crc_a == cc);
            e.m_b   = ce && (e.crc_b == cc);
            e.cnt   = (frame_bytes.size() > 65535) ? 16'hFFFF : 16'(frame_bytes.size());
            e.perr  = m_perr;
            e.beerr = m_beerr;
            exp_q.push_back(e);
            in_frame = 1'b0;
        end else begin
            in_frame = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] be, input logic sop,
                             input logic eop, input logic ce, input logic [31:0] cc,
                             output int waits);
        bit done;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = d; in_be = be; in_sop = sop; in_eop = eop;
            chk_en = ce; chk_crc = cc;
            #1;
            done = in_ready_a && in_ready_b;
            @(posedge clk);
            if (done) begin
                model_beat(d, be, sop, eop, ce, cc);
            end else begin
                waits++;
                if (waits > 500) begin
                    tests++;
                    fails++;
                    $display("FAIL accept_timeout: got no in_ready in %0d cycles, required acceptance", waits);
                    done = 1'b1;
                end
            end
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_abc(input logic ce, input logic [31:0] cc, input logic [3:0] be_mid);
        int w;
        send_beat(32'h31323334, 4'hF,   1'b1, 1'b0, 1'b0, 32'h0, w);
        send_beat(32'h35363738, be_mid, 1'b0, 1'b0, 1'b0, 32'h0, w);
        send_beat(32'h39AABBCC, 4'h8,   1'b0, 1'b1, ce,   cc,    w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = (rdy_mode == 2);
            #2;
            if (!rst && out_valid_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got crc %h, required no result", crc_out_a);
                end else begin
                    e = exp_q.pop_front();
                    check("out_valid_b", 32'(out_valid_b), 32'd1);
                    check("crc_a",       crc_out_a, e.crc_a);
                    check("crc_b",       crc_out_b, e.crc_b);
                    check("match_a",     32'(crc_match_a), 32'(e.m_a));
                    check("match_b",     32'(crc_match_b), 32'(e.m_b));
                    check("byte_cnt",    32'(byte_cnt_a), 32'(e.cnt));
                    check("byte_cnt_b",  32'(byte_cnt_b), 32'(e.cnt));
                    check("proto_err",   32'(proto_err_a), 32'(e.perr));
                    check("be_err",      32'(be_err_a), 32'(e.beerr));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end

    initial begin
        int          w;
        bit          sop, eop;
        logic [3:0]  be;
        logic [31:0] d, cc;
        logic        ce;
        int          nb;
        bq_t         t;
        logic [3:0]  legal_tab [4];

        legal_tab[0] = 4'b1000; legal_tab[1] = 4'b1100;
        legal_tab[2] = 4'b1110; legal_tab[3] = 4'b1111;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_be = '0;
        in_sop = 1'b0; in_eop = 1'b0; chk_en = 1'b0; chk_crc = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready_a),  32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_crc_a",     crc_out_a,        32'd0);
        check("rst_crc_b",     crc_out_b,        32'd0);
        check("rst_match",     32'(crc_match_a), 32'd0);
        check("rst_byte_cnt",  32'(byte_cnt_a),  32'd0);
        check("rst_proto_err", 32'(proto_err_a), 32'd0);
        check("rst_be_err",    32'(be_err_b),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // "123456789" under both configurations, with and without a matching expected CRC
        dir_en = 1'b1; dir_a = 32'h89A1897F; dir_b = 32'hCBF43926;
        send_abc(1'b1, 32'hCBF43926, 4'hF);
        send_abc(1'b1, 32'h0, 4'hF);
        send_abc(1'b0, 32'h89A1897F, 4'hF);
        drain();

        // Result stall: engine must refuse beats and hold outputs
        rdy_mode = 1;
        send_abc(1'b0, 32'h0, 4'hF);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("stall_in_ready",  32'(in_ready_a),  32'd0);
            check("stall_out_valid", 32'(out_valid_a), 32'd1);
            check("stall_crc_a",     crc_out_a,        32'h89A1897F);
            check("stall_crc_b",     crc_out_b,        32'hCBF43926);
            check("stall_byte_cnt",  32'(byte_cnt_a),  32'd9);
        end
        rdy_mode = 2;
        send_beat(32'h31323334, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, w);
        check("release_same_cycle_accept", 32'(w), 32'd0);
        send_beat(32'h35363738, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, w);
        send_beat(32'h39000000, 4'h8, 1'b0, 1'b1, 1'b0, 32'h0, w);

        // Non-contiguous enable on the middle beat behaves as all-ones
        send_abc(1'b0, 32'h0, 4'b1010);
        // Sop mid-frame drops the first frame
        send_beat(32'h31323334, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, w);
        send_beat(32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, w);
        send_abc(1'b0, 32'h0, 4'hF);
        drain();

        // Reset mid-frame aborts with no result
        send_beat(32'h31323334, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0, w);
        @(negedge clk);
        rst = 1'b1;
        in_frame = 1'b0;
        frame_bytes.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid_a), 32'd0);
        @(negedge clk);
        #1;
        check("midrst_out_valid_hold", 32'(out_valid_b), 32'd0);
        rst = 1'b0;
        send_abc(1'b0, 32'h0, 4'hF);
        drain();

        // Randomized frames against the byte-level reference model
        dir_en   = 1'b0;
        rdy_mode = 0;
        for (int f = 0; f < 250; f++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                sop = (b == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
                eop = (b == nb - 1);
                be  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_tab[$urandom_range(0, 3)];
                d   = $urandom;
                ce  = 1'($urandom_range(0, 1));
                cc  = $urandom;
                if (eop) begin
                    if (sop || !in_frame) t.delete();
                    else                  t = frame_bytes;
                    t = append_beat(t, d, be);
                    case ($urandom_range(0, 2))
                        0:       cc = crc_a_of(t);
                        1:       cc = crc_b_of(t);
                        default: cc = $urandom;
                    endcase
                end
                send_beat(d, be, sop, eop, ce, cc, w);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end
        rdy_mode = 2;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
